// File: rtl/usb_phy_pkg.sv
// Shared USB 3.0 PHY constants: K-symbol codes and the Gen1 scrambler seed/polynomial.
package usb_phy_pkg;

    localparam logic [15:0] SCR_SEED = 16'hFFFF;
    localparam logic [15:0] SCR_POLY = 16'h0039;

    localparam logic [7:0] K_SKP = 8'h3C;  // K28.1
    localparam logic [7:0] K_SDP = 8'h5C;  // K28.2
    localparam logic [7:0] K_EDB = 8'h7C;  // K28.3
    localparam logic [7:0] K_SUB = 8'h9C;  // K28.4
    localparam logic [7:0] K_COM = 8'hBC;  // K28.5
    localparam logic [7:0] K_SHP = 8'hFB;  // K27.7
    localparam logic [7:0] K_END = 8'hFD;  // K29.7

    typedef enum logic [1:0] {
        SymData,
        SymCom,
        SymSkp,
        SymOtherK
    } sym_kind_e;

    function automatic sym_kind_e classify_sym(input logic [7:0] sym, input logic is_k,
                                               input logic [7:0] com, input logic [7:0] skp);
        if (!is_k)       return SymData;
        else if (sym == com) return SymCom;
        else if (sym == skp) return SymSkp;
        else             return SymOtherK;
    endfunction

endpackage

// File: rtl/usb_lfsr_step8.sv
// Combinational 8-step advance of the Galois scrambler LFSR; key bit i comes from step i.
module usb_lfsr_step8
    import usb_phy_pkg::*;
#(
    parameter logic [15:0] POLY = SCR_POLY
) (
    input  logic [15:0] lfsr,
    output logic [7:0]  key8,
    output logic [15:0] next_lfsr
);

    logic [15:0] state;

    always_comb begin
        state = lfsr;
        key8  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            key8[i] = state[15];
            state   = {state[14:0], 1'b0} ^ (state[15] ? POLY : 16'h0000);
        end
        next_lfsr = state;
    end

endmodule

// File: rtl/usb_scrambler.sv
// Gen1 transmit scrambler: XORs data bytes with the LFSR keystream, passes K symbols through,
// reseeds on COM and freezes on SKP. One registered cycle of latency.
module usb_scrambler
    import usb_phy_pkg::*;
#(
    parameter logic [15:0] SEED    = SCR_SEED,
    parameter logic [15:0] POLY    = SCR_POLY,
    parameter logic [7:0]  COM_SYM = K_COM,
    parameter logic [7:0]  SKP_SYM = K_SKP
) (
    input  logic       SCR_CLK,
    input  logic       SCR_RST,
    input  logic       SCR_VALID_IN,
    input  logic [7:0] SCR_IN,
    input  logic       SCR_KI,
    input  logic       SCR_DIS,
    output logic       SCR_VALID_OUT,
    output logic [7:0] SCR_OUT,
    output logic       SCR_KO
);

    logic [15:0] lfsr_q, lfsr_d, lfsr_step;
    logic [7:0]  key8;
    logic [7:0]  out_d, out_q;
    logic        valid_q, ko_q;
    sym_kind_e   kind;

    usb_lfsr_step8 #(
        .POLY (POLY)
    ) u_step8 (
        .lfsr      (lfsr_q),
        .key8      (key8),
        .next_lfsr (lfsr_step)
    );

    always_comb begin
        kind   = classify_sym(SCR_IN, SCR_KI, COM_SYM, SKP_SYM);
        lfsr_d = lfsr_q;
        out_d  = SCR_IN;
        unique case (kind)
            SymData: begin
                // Disable only bypasses the XOR; the LFSR keeps step with the far end.
                out_d  = SCR_DIS ? SCR_IN : (SCR_IN ^ key8);
                lfsr_d = lfsr_step;
            end
            SymCom:    lfsr_d = SEED;
            SymSkp:    lfsr_d = lfsr_q;
            SymOtherK: lfsr_d = lfsr_step;
            default:   lfsr_d = lfsr_q;
        endcase
    end

    always_ff @(posedge SCR_CLK or negedge SCR_RST) begin
        if (!SCR_RST) begin
            lfsr_q  <= SEED;
            valid_q <= 1'b0;
            out_q   <= 8'h00;
            ko_q    <= 1'b0;
        end else begin
            valid_q <= SCR_VALID_IN;
            if (SCR_VALID_IN) begin
                lfsr_q <= lfsr_d;
                out_q  <= out_d;
                ko_q   <= SCR_KI;
            end
        end
    end

    assign SCR_VALID_OUT = valid_q;
    assign SCR_OUT       = out_q;
    assign SCR_KO        = ko_q;

endmodule

// File: tb/tb_usb_scrambler.sv
// Directed self-checking bench for usb_scrambler using hand-computed Gen1 keystream bytes.
module tb_usb_scrambler;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [7:0] din;
    logic       kin;
    logic       dis;
    logic       valid_out;
    logic [7:0] dout;
    logic       kout;

    int errors = 0;
    int checks = 0;

    usb_scrambler dut (
        .SCR_CLK       (clk),
        .SCR_RST       (rst_n),
        .SCR_VALID_IN  (valid_in),
        .SCR_IN        (din),
        .SCR_KI        (kin),
        .SCR_DIS       (dis),
        .SCR_VALID_OUT (valid_out),
        .SCR_OUT       (dout),
        .SCR_KO        (kout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one symbol, clock it in, return 1 time unit after the edge.
    task automatic send(input logic v, input logic [7:0] b, input logic k, input logic d);
        @(negedge clk);
        valid_in = v;
        din      = b;
        kin      = k;
        dis      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        din      = 8'h00;
        kin      = 1'b0;
        dis      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_out: got %h want 00", dout);
        end
        checks++;
        if (kout !== 1'b0) begin
            errors++; $display("FAIL reset_ko: got %b want 0", kout);
        end
    endtask

    task automatic test_keystream();
        logic [7:0] exp [4];
        exp[0] = 8'hFF; exp[1] = 8'h17; exp[2] = 8'hC0; exp[3] = 8'h14;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 8'h00, 1'b0, 1'b0);
            checks++;
            if (dout !== exp[i] || valid_out !== 1'b1 || kout !== 1'b0) begin
                errors++;
                $display("FAIL keystream[%0d]: got %h/v%b/k%b want %h/v1/k0", i, dout,
                         valid_out, kout, exp[i]);
            end
        end
    endtask

    task automatic test_com();
        do_reset();
        for (int i = 0; i < 3; i++) send(1'b1, 8'h00, 1'b0, 1'b0);
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        checks++;
        if (dout !== 8'hBC || kout !== 1'b1) begin
            errors++; $display("FAIL com_pass: got %h/k%b want bc/k1", dout, kout);
        end
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'hFF || kout !== 1'b0) begin
            errors++; $display("FAIL com_reseed: got %h/k%b want ff/k0", dout, kout);
        end
        // Back-to-back COMs each reseed.
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'hFF) begin
            errors++; $display("FAIL com_b2b: got %h want ff", dout);
        end
        // BC as data is scrambled and does not reseed.
        do_reset();
        send(1'b1, 8'hBC, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'h43 || kout !== 1'b0) begin
            errors++; $display("FAIL com_as_data: got %h/k%b want 43/k0", dout, kout);
        end
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'h17) begin
            errors++; $display("FAIL com_as_data_next: got %h want 17", dout);
        end
    endtask

    task automatic test_skp();
        do_reset();
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'hFF) begin
            errors++; $display("FAIL skp_pre: got %h want ff", dout);
        end
        send(1'b1, 8'h3C, 1'b1, 1'b0);
        checks++;
        if (dout !== 8'h3C || kout !== 1'b1) begin
            errors++; $display("FAIL skp_pass: got %h/k%b want 3c/k1", dout, kout);
        end
        send(1'b1, 8'h3C, 1'b1, 1'b0);
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'h17 || kout !== 1'b0) begin
            errors++; $display("FAIL skp_hold: got %h/k%b want 17/k0", dout, kout);
        end
        // A non-COM/SKP K symbol advances the LFSR.
        send(1'b1, 8'h5C, 1'b1, 1'b0);
        checks++;
        if (dout !== 8'h5C || kout !== 1'b1) begin
            errors++; $display("FAIL otherk_pass: got %h/k%b want 5c/k1", dout, kout);
        end
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'h14) begin
            errors++; $display("FAIL otherk_adv: got %h want 14", dout);
        end
    endtask

    task automatic test_disable();
        do_reset();
        send(1'b1, 8'hA5, 1'b0, 1'b1);
        checks++;
        if (dout !== 8'hA5) begin
            errors++; $display("FAIL dis_a5: got %h want a5", dout);
        end
        send(1'b1, 8'h5A, 1'b0, 1'b1);
        checks++;
        if (dout !== 8'h5A) begin
            errors++; $display("FAIL dis_5a: got %h want 5a", dout);
        end
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'hC0) begin
            errors++; $display("FAIL dis_realign: got %h want c0", dout);
        end
    endtask

    task automatic test_gaps();
        int pulses;
        pulses = 0;
        do_reset();
        send(1'b1, 8'h00, 1'b0, 1'b0);
        if (valid_out === 1'b1) pulses++;
        checks++;
        if (dout !== 8'hFF) begin
            errors++; $display("FAIL gap_first: got %h want ff", dout);
        end
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'h55, 1'b1, 1'b0);
            if (valid_out === 1'b1) pulses++;
            checks++;
            if (dout !== 8'hFF || kout !== 1'b0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold[%0d]: got %h/k%b/v%b want ff/k0/v0", i, dout, kout,
                         valid_out);
            end
        end
        send(1'b1, 8'h00, 1'b0, 1'b0);
        if (valid_out === 1'b1) pulses++;
        checks++;
        if (dout !== 8'h17) begin
            errors++; $display("FAIL gap_second: got %h want 17", dout);
        end
        send(1'b0, 8'h00, 1'b0, 1'b0);
        if (valid_out === 1'b1) pulses++;
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL gap_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(1'b1, 8'h00, 1'b0, 1'b0);
        send(1'b1, 8'h3C, 1'b1, 1'b0);
        valid_in = 1'b1;
        din      = 8'h00;
        kin      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || kout !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got %h/k%b/v%b want 00/k0/v0", dout, kout, valid_out);
        end
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout !== 8'hFF || valid_out !== 1'b1) begin
            errors++; $display("FAIL async_rst_seed: got %h/v%b want ff/v1", dout, valid_out);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        din      = 8'h00;
        kin      = 1'b0;
        dis      = 1'b0;
        test_reset();
        test_keystream();
        test_com();
        test_skp();
        test_disable();
        test_gaps();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
